// File: rtl/pps_pkg.sv
// pps_pkg: shared state encoding, default width and round-table entry type for ping_pong_sequencer
package pps_pkg;
  localparam int CW_DEF = 4;
  localparam int CW_MAX = 16;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, NEXT, DONE} state_t;
  typedef struct packed {
    logic [CW_MAX-1:0] max;
    logic [CW_MAX-1:0] min;
  } entry_t;
endpackage

// File: rtl/pps_rr_arb.sv
// pps_rr_arb: two-requester round-robin arbiter with sticky pending bits and a one-hot grant
module pps_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic [1:0] pend_q, pend_d, pick;
  logic ptr_q, ptr_d, last_q, last_d;
  always_comb begin
    pick = ptr_q ? (pend_q[1] ? 2'b10 : {1'b0, pend_q[0]}) : (pend_q[0] ? 2'b01 : {pend_q[1], 1'b0});
    gnt = (en && !last_q) ? pick : 2'b00;
    pend_d = clr ? 2'b00 : (pend_q & ~gnt) | req;
    ptr_d = ptr_q ^ (|gnt);
    last_d = |gnt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 2'b00;
      ptr_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ptr_q <= ptr_d;
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/ping_pong_sequencer.sv
// ping_pong_sequencer: steps the ping-pong counter through a (max,min) round table; define PING_PONG_SEQ_FLIP_ARB_EN to arbitrate flip requests
module ping_pong_sequencer #(
  parameter int NUM_ROUNDS = 4,
  parameter int BOUNCES = 4,
  parameter int CW = pps_pkg::CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pause,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_addr,
  input  logic [CW-1:0] cfg_max,
  input  logic [CW-1:0] cfg_min,
  input  logic [1:0]    flip_req,
  input  logic [CW-1:0] cnt_out,
  input  logic          cnt_dir,
  output logic          cnt_rst_n,
  output logic          cnt_enable,
  output logic          cnt_flip,
  output logic [CW-1:0] cnt_max,
  output logic [CW-1:0] cnt_min,
  output logic [1:0]    flip_grant,
  output logic [3:0]    round_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);
  import pps_pkg::*;
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] NB = 4'(BOUNCES);
  state_t state_q, state_d;
  logic [3:0] round_q, round_d, bcnt_q, bcnt_d;
  logic [CW-1:0] max_q, max_d, min_q, min_d, prev_out_q;
  logic prev_dir_q, prev_ok_q, err_q, err_d, bounce, bad;
  entry_t tbl_q [16];
  entry_t ent;
  always_comb begin
    ent = tbl_q[round_q];
    bad = ent.max[CW-1:0] <= ent.min[CW-1:0];
    // prev_ok masks the first RUN cycle, where prev_* still hold the pre-reset counter
    bounce = prev_ok_q && cnt_dir != prev_dir_q && (prev_out_q == max_q || prev_out_q == min_q);
    state_d = state_q;
    round_d = round_q;
    bcnt_d = bcnt_q;
    max_d = max_q;
    min_d = min_q;
    err_d = err_q;
    case (state_q)
      LOAD: begin
        max_d = ent.max[CW-1:0];
        min_d = ent.min[CW-1:0];
        bcnt_d = '0;
        err_d = err_q | bad;
        state_d = bad ? NEXT : RUN;
      end
      RUN, PAUSE: begin
        bcnt_d = bcnt_q + 4'(bounce);
        state_d = bcnt_d == NB ? NEXT : pause ? PAUSE : RUN;
      end
      NEXT: begin
        round_d = round_q == LAST ? round_q : round_q + 4'd1;
        state_d = round_q == LAST ? DONE : LOAD;
      end
      default: ;
    endcase
    if (start) begin
      state_d = LOAD;
      round_d = '0;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      bcnt_q <= '0;
      max_q <= '0;
      min_q <= '0;
      err_q <= 1'b0;
      prev_out_q <= '0;
      prev_dir_q <= 1'b0;
      prev_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      bcnt_q <= bcnt_d;
      max_q <= max_d;
      min_q <= min_d;
      err_q <= err_d;
      prev_out_q <= cnt_out;
      prev_dir_q <= cnt_dir;
      prev_ok_q <= state_q == RUN || state_q == PAUSE;
    end
  end
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_addr <= LAST) tbl_q[cfg_addr] <= '{max: CW_MAX'(cfg_max), min: CW_MAX'(cfg_min)};
  end
`ifdef PING_PONG_SEQ_FLIP_ARB_EN
  pps_rr_arb u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .clr(start),
    .en(state_q == RUN && !start && min_q < cnt_out && cnt_out < max_q),
    .req(flip_req),
    .gnt(flip_grant)
  );
`else
  logic unused_req;
  assign unused_req = ^flip_req;
  assign flip_grant = 2'b00;
`endif
  logic unused_ent;
  assign unused_ent = ^{ent.max, ent.min};
  assign cnt_flip = |flip_grant;
  // a skipped (invalid) round never resets the counter
  assign cnt_rst_n = rst_n && !(state_q == LOAD && !bad);
  assign cnt_enable = state_q == RUN;
  assign cnt_max = max_q;
  assign cnt_min = min_q;
  assign round_idx = round_q;
  assign busy = state_q == LOAD || state_q == RUN || state_q == PAUSE || state_q == NEXT;
  assign done = state_q == DONE;
  assign err = err_q;
endmodule

// File: tb/tb_ping_pong_sequencer.sv
// tb_ping_pong_sequencer: directed vectors for ping_pong_sequencer with NUM_ROUNDS=2, BOUNCES=2, CW=4
module tb_ping_pong_sequencer;
`ifdef PING_PONG_SEQ_FLIP_ARB_EN
  localparam int ARB = 1;
`else
  localparam int ARB = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0, cfg_we = 1'b0, cnt_dir = 1'b0;
  logic [3:0] cfg_addr = '0, cfg_max = '0, cfg_min = '0, cnt_out = '0;
  logic [1:0] flip_req = '0;
  logic cnt_rst_n, cnt_enable, cnt_flip, busy, done, err;
  logic [3:0] cnt_max, cnt_min, round_idx;
  logic [1:0] flip_grant;
  int pass_n = 0, tot_n = 0;
  always #5 clk = ~clk;
  ping_pong_sequencer #(.NUM_ROUNDS(2), .BOUNCES(2), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_max(cfg_max), .cfg_min(cfg_min), .flip_req(flip_req), .cnt_out(cnt_out), .cnt_dir(cnt_dir),
    .cnt_rst_n(cnt_rst_n), .cnt_enable(cnt_enable), .cnt_flip(cnt_flip), .cnt_max(cnt_max),
    .cnt_min(cnt_min), .flip_grant(flip_grant), .round_idx(round_idx), .busy(busy), .done(done), .err(err)
  );
  typedef struct {
    int st, pa, rq, o, d;
    logic [19:0] e;
  } vec_t;
  vec_t tv [$];
  function automatic logic [19:0] pk(input int rn, en, bz, dn, er, gr, rd, mx, mn);
    return {1'(rn), 1'(en), 1'(bz), 1'(dn), 1'(er), |2'(gr), 2'(gr), 4'(rd), 4'(mx), 4'(mn)};
  endfunction
  function automatic vec_t mk(input int st, pa, rq, o, d, input logic [19:0] e);
    return '{st, pa, rq, o, d, e};
  endfunction
  function automatic logic [19:0] outs();
    return {cnt_rst_n, cnt_enable, busy, done, err, cnt_flip, flip_grant, round_idx, cnt_max, cnt_min};
  endfunction
  task automatic drive(input int st, pa, rq, o, d);
    @(negedge clk);
    start = 1'(st);
    pause = 1'(pa);
    flip_req = 2'(rq);
    cnt_out = 4'(o);
    cnt_dir = 1'(d);
    #1;
  endtask
  task automatic check(input string nm, input logic [19:0] exp);
    logic [19:0] got;
    got = outs();
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %b expected %b (rstn en busy done err flip grant[2] round[4] max[4] min[4])", nm, got, exp);
  endtask
  task automatic cfg(input int a, mx, mn);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_max = 4'(mx);
    cfg_min = 4'(mn);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask
  initial begin
    logic [19:0] idl, ld0, run0, nx0, ld1, run1, nx1, dn1, r0e, r1e, pz1;
    idl = pk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    ld0 = pk(0, 0, 1, 0, 0, 0, 0, 0, 0);
    run0 = pk(1, 1, 1, 0, 0, 0, 0, 5, 2);
    nx0 = pk(1, 0, 1, 0, 0, 0, 0, 5, 2);
    ld1 = pk(0, 0, 1, 0, 0, 0, 1, 5, 2);
    run1 = pk(1, 1, 1, 0, 0, 0, 1, 3, 0);
    nx1 = pk(1, 0, 1, 0, 0, 0, 1, 3, 0);
    dn1 = pk(1, 0, 0, 1, 0, 0, 1, 3, 0);
    tv.push_back(mk(1, 0, 0, 0, 1, idl));
    tv.push_back(mk(0, 0, 0, 2, 1, ld0));
    tv.push_back(mk(0, 0, 0, 2, 1, run0));
    tv.push_back(mk(0, 0, 0, 3, 1, run0));
    tv.push_back(mk(0, 0, 0, 4, 1, run0));
    tv.push_back(mk(0, 0, 0, 5, 1, run0));
    tv.push_back(mk(0, 0, 0, 4, 0, run0));
    tv.push_back(mk(0, 0, 0, 3, 0, run0));
    tv.push_back(mk(0, 0, 0, 2, 0, run0));
    tv.push_back(mk(0, 0, 0, 3, 1, run0));
    tv.push_back(mk(0, 0, 0, 4, 1, nx0));
    tv.push_back(mk(0, 0, 0, 4, 1, ld1));
    tv.push_back(mk(0, 0, 0, 0, 1, run1));
    tv.push_back(mk(0, 0, 0, 1, 1, run1));
    tv.push_back(mk(0, 0, 0, 2, 1, run1));
    tv.push_back(mk(0, 0, 0, 3, 1, run1));
    tv.push_back(mk(0, 0, 0, 2, 0, run1));
    tv.push_back(mk(0, 0, 0, 1, 0, run1));
    tv.push_back(mk(0, 0, 0, 0, 0, run1));
    tv.push_back(mk(0, 0, 0, 1, 1, run1));
    tv.push_back(mk(0, 0, 0, 2, 1, nx1));
    tv.push_back(mk(0, 0, 0, 2, 1, dn1));
    tv.push_back(mk(0, 0, 0, 2, 1, dn1));
    drive(0, 0, 0, 0, 0);
    check("reset", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    #1;
    check("idle", idl);
    cfg(0, 5, 2);
    cfg(1, 3, 0);
    foreach (tv[i]) begin
      drive(tv[i].st, tv[i].pa, tv[i].rq, tv[i].o, tv[i].d);
      check($sformatf("vec%0d", i), tv[i].e);
    end
    cfg(0, 7, 7);
    drive(1, 0, 0, 0, 1);
    check("b_done", dn1);
    drive(0, 0, 0, 0, 1);
    check("b_load_bad", pk(1, 0, 1, 0, 0, 0, 0, 3, 0));
    drive(0, 0, 0, 0, 1);
    check("b_next_err", pk(1, 0, 1, 0, 1, 0, 0, 7, 7));
    drive(0, 0, 0, 0, 1);
    check("b_load_r1", pk(0, 0, 1, 0, 1, 0, 1, 7, 7));
    r1e = pk(1, 1, 1, 0, 1, 0, 1, 3, 0);
    pz1 = pk(1, 0, 1, 0, 1, 0, 1, 3, 0);
    drive(0, 0, 0, 0, 1);
    check("b_run_r1", r1e);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 2, 1);
    drive(0, 0, 0, 3, 1);
    drive(0, 1, 0, 2, 0);
    check("c_bounce_pause", r1e);
    drive(0, 1, 0, 1, 0);
    check("c_paused", pz1);
    for (int k = 0; k < 3; k++) drive(0, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("c_pause_hold", pz1);
    drive(0, 0, 0, 1, 0);
    check("c_resume", r1e);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    check("c_b2", r1e);
    drive(0, 0, 0, 1, 1);
    check("c_next", pz1);
    drive(0, 0, 0, 1, 1);
    check("c_done_err", pk(1, 0, 0, 1, 1, 0, 1, 3, 0));
    cfg(0, 5, 2);
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 2, 1);
    check("d_load0", pk(0, 0, 1, 0, 0, 0, 0, 3, 0));
    drive(0, 0, 0, 2, 1);
    drive(0, 0, 0, 5, 1);
    drive(0, 0, 0, 4, 0);
    drive(0, 0, 0, 2, 0);
    drive(0, 0, 0, 3, 1);
    drive(0, 0, 0, 3, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 2, 0, 1);
    check("d_run_r1", run1);
    drive(1, 0, 0, 3, 1);
    check("d_start", run1);
    drive(0, 0, 0, 3, 1);
    check("d_restart_load", pk(0, 0, 1, 0, 0, 0, 0, 3, 0));
    drive(0, 0, 0, 3, 1);
    check("d_pend_dropped", run0);
    r0e = run0;
    drive(0, 0, 3, 3, 1);
    check("e_req", r0e);
    drive(0, 0, 1, 3, 1);
    check("e_g0", pk(1, 1, 1, 0, 0, ARB, 0, 5, 2));
    drive(0, 0, 0, 4, 0);
    check("e_gap", r0e);
    drive(0, 0, 0, 3, 0);
    check("e_g1", pk(1, 1, 1, 0, 0, 2 * ARB, 0, 5, 2));
    drive(0, 0, 0, 4, 1);
    check("e_gap2", r0e);
    drive(0, 0, 0, 5, 1);
    check("e_at_max", r0e);
    drive(0, 0, 0, 4, 0);
    check("e_g0_again", pk(1, 1, 1, 0, 0, ARB, 0, 5, 2));
    drive(0, 0, 0, 3, 0);
    check("e_still_run", r0e);
    drive(0, 0, 0, 2, 0);
    drive(0, 0, 0, 3, 1);
    drive(0, 0, 0, 3, 1);
    check("e_next", nx0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
